regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor to the CPU general-purpose register file, for the pipelined core. It has two combinational read ports and a main write port. A dedicated link-write port writes return addresses (pc+8) into a configurable link register. Optional write-to-read bypass is provided. A per-register busy scoreboard tracks in-flight producers and raises a read-after-write hazard to the issue stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; NREGS = 2**ADDR_W
LINK_REG, 31, index written by the link port
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
TRACE, 0, 1 = simulation-only $display of register contents on every write

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
ra_addr  in  ADDR_W  read port A index (rs)
rb_addr  in  ADDR_W  read port B index (rt)
ra_data  out  DATA_W  read port A data
rb_data  out  DATA_W  read port B data
ra_used  in  1  issuing instruction consumes port A
rb_used  in  1  issuing instruction consumes port B
hazard  out  1  RAW hazard; issue stage must stall
issue_en  in  1  instruction issues this cycle with a destination
issue_rd  in  ADDR_W  destination index of issuing instruction
wr_en  in  1  main write-back strobe
wr_addr  in  ADDR_W  write-back index
wr_data  in  DATA_W  write-back data
link_en  in  1  link write strobe
link_pc  in  DATA_W  PC of linking instruction
busy_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, all busy bits 0, busy_cnt 0. The read ports show 0 while in reset. hazard=0 while in reset.
- Register 0:
  - Reads always return 0.
  - Writes to index 0 are discarded.
  - issue_rd=0 never sets a busy bit.
- Reads:
  - Combinational, zero latency.
  - With BYPASS=1, a read whose index equals an index written this cycle returns the data about to be written.
  - With BYPASS=0, a read returns the stored value; new data is visible the cycle after the edge.
- Main write: on a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
- Link write:
  - On a rising edge with link_en=1, reg[LINK_REG] <= link_pc + 8, truncated mod 2**DATA_W (0xFFFFFFFC -> 0x00000004).
  - If wr_en and link_en target the same index in one cycle, the link write wins and wr_data is dropped.
  - Bypass then forwards the link value.
- Scoreboard:
  - Set: issue_en=1 and issue_rd!=0 sets busy[issue_rd] at the edge.
  - Clear: a completed main write clears busy[wr_addr] at the edge. A link write clears busy[LINK_REG] at the edge.
  - Set and clear on the same index in the same cycle: set wins, because a new producer supersedes the old one.
  - Clearing an already-clear bit is a no-op.
  - Setting an already-busy bit keeps it busy; there is no counting of multiple producers.
- hazard (combinational): (ra_used & busy[ra_addr] & !fwdA) | (rb_used & busy[rb_addr] & !fwdB).
  - fwdX = 1 only when BYPASS=1 and port X's index is being written this cycle.
  - Index 0 never hazards.
- busy_cnt:
  - Registered popcount of the busy vector, updated at the same edge as the busy bits.
  - Range 0..NREGS-1.
  - Increment/decrement net of simultaneous set and clear; no wrap.
- TRACE=1: after each write edge, print all NREGS registers, 8 per line, plus the written index and value. TRACE has no synthesis effect.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W defaults
  - the LINK_REG constant (31)
  - the link offset constant LINK_OFS=8
  - the reg_idx_t typedef
- One natural sub-module: regfile_scoreboard. It owns the busy vector, set/clear priority, busy_cnt and the busy lookup used for hazard.
- Storage, write arbitration and bypass stay in regfile_sb.

Test Plan:
- Reset then read all indices -> every ra_data/rb_data=0, busy_cnt=0, hazard=0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write r5=0x12345678 with ra_addr=5 in the same cycle -> BYPASS=1: ra_data=0x12345678 that cycle. BYPASS=0: old value that cycle, new value the next cycle.
- link_en with link_pc=0x00400010 and wr_en to r31 with 0xAAAA5555 in the same cycle -> r31=0x00400018. Also link_pc=0xFFFFFFFC -> r31=0x00000004.
- issue_en rd=7, next cycle ra_used with ra_addr=7 -> hazard=1, busy_cnt=1. wr_en r7 that cycle with BYPASS=1 -> hazard=0 that cycle, busy_cnt=0 next cycle.
- issue_en rd=9 and wr_en r9 in the same cycle -> busy[9] remains 1, busy_cnt=1. Issue rd=0 -> no busy change.
- Set busy on r3, r4, r31, then drive rst=0 asynchronously mid-cycle -> busy_cnt=0, all registers 0, hazard=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants: default widths, link register index and return-address offset.
package cpu_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int LINK_REG_DEF = 31;
  localparam int LINK_OFS     = 8;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with registered popcount; set beats clear on the same index.
// Busy lookups are combinational, state updates at the clock edge, no backpressure.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              wr_clr,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic              link_clr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  always_comb begin
    busy_nxt = busy;
    if (wr_clr) busy_nxt[wr_idx] = 1'b0;
    if (link_clr) busy_nxt[LINK_REG] = 1'b0;
    // A new producer supersedes the completing one, so set is applied last.
    if (set_en && (set_idx != '0)) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign busy_a = busy[ra_addr];
  assign busy_b = busy[rb_addr];
endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with link port, optional same-cycle bypass and RAW scoreboard.
// Reads and hazard are combinational; writes and busy state land at the edge; no backpressure.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int BYPASS   = 1,
  parameter int TRACE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              ra_used,
  input  logic              rb_used,
  output logic              hazard,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_pc,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] link_data;
  logic              wr_hit;
  logic              main_wr;
  logic              fwd_a, fwd_b;
  logic              busy_a, busy_b;

  assign link_data = link_pc + DATA_W'(LINK_OFS);
  assign wr_hit    = wr_en && (wr_addr != '0);
  // On an index collision the link write owns the register.
  assign main_wr   = wr_hit && !(link_en && (wr_addr == LINK_IDX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (main_wr) regs[wr_addr] <= wr_data;
      if (link_en) regs[LINK_IDX] <= link_data;
    end
  end

  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W:0] r;
    r = '0;
    if (idx != '0) begin
      r = {1'b0, regs[idx]};
      if (BYPASS != 0) begin
        if (link_en && (idx == LINK_IDX)) r = {1'b1, link_data};
        else if (main_wr && (idx == wr_addr)) r = {1'b1, wr_data};
      end
    end
    if (!rst) r = '0;
    return r;
  endfunction

  always_comb begin
    {fwd_a, ra_data} = read_port(ra_addr);
    {fwd_b, rb_data} = read_port(rb_addr);
  end

  assign hazard = rst && ((ra_used && busy_a && !fwd_a) || (rb_used && busy_b && !fwd_b));

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .LINK_REG (LINK_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_en),
    .set_idx  (issue_rd),
    .wr_clr   (wr_hit),
    .wr_idx   (wr_addr),
    .link_clr (link_en),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .busy_cnt (busy_cnt)
  );

  if (TRACE != 0) begin : g_trace
`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (rst && (main_wr || link_en)) begin
        for (int i = 0; i < NREGS; i += 8) begin
          $strobe("r%0d: %h %h %h %h %h %h %h %h", i, regs[i], regs[i+1], regs[i+2],
                  regs[i+3], regs[i+4], regs[i+5], regs[i+6], regs[i+7]);
        end
        if (main_wr) $strobe("write r%0d = %h", wr_addr, wr_data);
        if (link_en) $strobe("link r%0d = %h", LINK_IDX, link_data);
      end
    end
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one bypassing and one non-bypassing instance driven in parallel.
module tb_regfile_sb;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra_addr, rb_addr, issue_rd, wr_addr;
  logic        ra_used, rb_used, issue_en, wr_en, link_en;
  logic [31:0] wr_data, link_pc;

  logic [31:0] ra_data, rb_data, ra_data_nb, rb_data_nb;
  logic        hazard, hazard_nb;
  logic [5:0]  busy_cnt, busy_cnt_nb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data), .ra_used(ra_used), .rb_used(rb_used),
    .hazard(hazard), .issue_en(issue_en), .issue_rd(issue_rd), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en), .link_pc(link_pc),
    .busy_cnt(busy_cnt)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data_nb), .rb_data(rb_data_nb), .ra_used(ra_used), .rb_used(rb_used),
    .hazard(hazard_nb), .issue_en(issue_en), .issue_rd(issue_rd), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en), .link_pc(link_pc),
    .busy_cnt(busy_cnt_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 0; wr_en = 0; link_en = 0; ra_used = 0; rb_used = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; idle();
    ra_addr = 0; rb_addr = 0; issue_rd = 0; wr_addr = 0; wr_data = 0; link_pc = 0;

    // In reset: outputs held at zero even with a pending bypass write.
    wr_en = 1; wr_addr = 5; wr_data = 32'h5555_AAAA; ra_addr = 5; ra_used = 1;
    #1;
    check("rst_ra_bypass", ra_data, 32'h0);
    check("rst_busy_cnt", {26'b0, busy_cnt}, 32'd0);
    check("rst_hazard", {31'b0, hazard}, 32'd0);
    idle();
    #11 rst = 1;   // released between clock edges

    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i); rb_addr = 5'(31 - i);
      #1;
      check("init_ra", ra_data, 32'h0);
      check("init_rb_nb", rb_data_nb, 32'h0);
    end
    check("init_hazard", {31'b0, hazard}, 32'd0);

    // r0 ignores writes and is never forwarded.
    wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF; ra_addr = 0;
    #1;
    check("r0_no_fwd", ra_data, 32'h0);
    tick(); idle();
    check("r0_after", ra_data, 32'h0);
    check("r0_after_nb", ra_data_nb, 32'h0);

    // Bypass vs. registered read.
    wr_en = 1; wr_addr = 5; wr_data = 32'h1234_5678; ra_addr = 5; rb_addr = 5;
    #1;
    check("byp_ra", ra_data, 32'h1234_5678);
    check("nobyp_ra", ra_data_nb, 32'h0);
    tick(); idle();
    check("byp_ra_next", ra_data, 32'h1234_5678);
    check("nobyp_rb_next", rb_data_nb, 32'h1234_5678);

    // Link beats main write to r31; link forwarded on bypass.
    link_en = 1; link_pc = 32'h0040_0010; wr_en = 1; wr_addr = 31; wr_data = 32'hAAAA_5555;
    ra_addr = 31;
    #1;
    check("link_fwd", ra_data, 32'h0040_0018);
    check("link_nofwd", ra_data_nb, 32'h0);
    tick(); idle();
    check("link_wins", ra_data, 32'h0040_0018);
    check("link_wins_nb", ra_data_nb, 32'h0040_0018);
    link_en = 1; link_pc = 32'hFFFF_FFFC;
    tick(); idle();
    check("link_wrap", ra_data_nb, 32'h0000_0004);

    // RAW hazard on r7, resolved by same-cycle write-back only with bypass.
    issue_en = 1; issue_rd = 7;
    tick(); idle();
    ra_used = 1; ra_addr = 7;
    #1;
    check("haz_set", {31'b0, hazard}, 32'd1);
    check("haz_cnt", {26'b0, busy_cnt}, 32'd1);
    wr_en = 1; wr_addr = 7; wr_data = 32'h77;
    #1;
    check("haz_fwd", {31'b0, hazard}, 32'd0);
    check("haz_nofwd", {31'b0, hazard_nb}, 32'd1);
    tick(); idle();
    ra_used = 1;
    #1;
    check("haz_clr_cnt", {26'b0, busy_cnt}, 32'd0);
    check("haz_clr", {31'b0, hazard_nb}, 32'd0);
    idle();

    // Set beats clear on r9; rd=0 and re-issue leave the count alone.
    issue_en = 1; issue_rd = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    tick(); idle();
    rb_used = 1; rb_addr = 9;
    #1;
    check("setwin_cnt", {26'b0, busy_cnt}, 32'd1);
    check("setwin_haz", {31'b0, hazard}, 32'd1);
    idle();
    issue_en = 1; issue_rd = 0; ra_used = 1; ra_addr = 0;
    #1;
    check("r0_no_haz", {31'b0, hazard}, 32'd0);
    tick();
    check("rd0_cnt", {26'b0, busy_cnt}, 32'd1);
    issue_rd = 9;
    tick();
    check("reissue_cnt", {26'b0, busy_cnt}, 32'd1);

    // Populate r3, r4, r31; then simultaneous set r10 / clear r3, and link vs. issue r31.
    issue_rd = 3; tick();
    issue_rd = 4; tick();
    issue_rd = 31; tick();
    check("cnt4", {26'b0, busy_cnt}, 32'd4);
    issue_rd = 10; wr_en = 1; wr_addr = 3; wr_data = 32'h33;
    tick(); wr_en = 0;
    check("net_cnt", {26'b0, busy_cnt_nb}, 32'd4);
    issue_rd = 31; link_en = 1; link_pc = 32'h100;
    tick(); idle();
    check("link_set_cnt", {26'b0, busy_cnt}, 32'd4);

    // Asynchronous mid-cycle reset.
    ra_used = 1; ra_addr = 4; rb_addr = 5;
    #1;
    check("pre_rst_haz", {31'b0, hazard}, 32'd1);
    @(posedge clk); #3;
    rst = 0;
    #1;
    check("arst_cnt", {26'b0, busy_cnt}, 32'd0);
    check("arst_haz", {31'b0, hazard}, 32'd0);
    check("arst_rb", rb_data_nb, 32'h0);
    #2 rst = 1;
    #1;
    check("post_rst_r5", rb_data, 32'h0);
    check("post_rst_haz", {31'b0, hazard_nb}, 32'd0);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
